pipe_latch_skid: RTL and testbench

Parametrised successor to the fixed IF/ID pipeline latch, usable between any two pipeline stages. Carries a DATA_W payload plus a halt sideband bit through a 2-entry skid buffer with a valid/ready handshake. Retains debug single-step gating and flush-on-jump, and adds back-pressure without data loss, a sticky halt and an optional stall counter. Instanced as IF/ID with DATA_W=64 ({pc, instruction}) and reusable for ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_latch_skid.sv | 217 +++++++++++++++++++++
 tb/tb_pipe_latch_skid.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_skid.sv
// -----------------------------------------------------------------------------
// pipe_latch_skid
//
// Generic pipeline latch placed between two pipeline stages. Each entry is a
// DATA_W payload plus a halt sideband bit. A 2-entry skid buffer (output
// register + skid register) sits behind a valid/ready handshake, so upstream
// back-pressure never loses data and o_ready never depends on i_ready or
// i_valid in the same cycle.
//
// Extra behaviour carried over from the fixed IF/ID latch:
//   - debug single-step gating (i_step=0 freezes every piece of state)
//   - flush-on-jump (i_flush discards both buffered entries)
// New behaviour:
//   - sticky o_halted once a halt entry has drained downstream
//   - optional saturating upstream stall counter
//
// Optional feature macro: STALL_CNT_EN
//   defined   -> o_stall_cnt counts upstream back-pressure cycles (saturating)
//   undefined -> counter logic absent, o_stall_cnt tied to 0
//
// Parameters:
//   DATA_W  payload width (>= 1)
//   CNT_W   stall counter width (>= 1)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   i_step       debug advance enable; 0 freezes all state
//   i_flush      discard all buffered entries
//   i_valid      upstream entry valid
//   o_ready      block can accept an entry this cycle
//   i_data       upstream payload
//   i_halt       upstream entry is the stop-pipe marker
//   o_valid      output entry valid
//   i_ready      downstream accepts the output entry
//   o_data       output payload (0 when o_valid=0)
//   o_halt       halt bit of the output entry (0 when o_valid=0)
//   o_halted     sticky: a halt entry has drained downstream
//   o_stall_cnt  upstream back-pressure cycle count
// -----------------------------------------------------------------------------
module pipe_latch_skid #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_halt,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_halt,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_halt_q, out_halt_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_halt_q, skid_halt_d;
  logic              halted_q, halted_d;

  logic              out_valid;
  logic              skid_valid;
  logic              in_fire;
  logic              out_fire;

  // Occupancy is fully encoded by the state; no separate valid flops.
  assign out_valid  = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  // Ready looks only at registered state and i_step, which breaks the
  // combinational ready path between neighbouring stages.
  assign o_ready  = i_step & ~skid_valid & ~halted_q;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = out_valid & i_ready & i_step;

  assign o_valid  = out_valid;
  assign o_data   = out_data_q;
  assign o_halt   = out_halt_q;
  assign o_halted = halted_q;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_halt_d  = out_halt_q;
    skid_data_d = skid_data_q;
    skid_halt_d = skid_halt_q;
    halted_d    = halted_q;

    if (i_step) begin
      // A drained halt entry still counts even when flushed in the same cycle.
      if (out_fire && out_halt_q) begin
        halted_d = 1'b1;
      end

      if (i_flush) begin
        state_d     = ST_EMPTY;
        out_data_d  = '0;
        out_halt_d  = 1'b0;
        skid_data_d = '0;
        skid_halt_d = 1'b0;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d    = ST_ONE;
              out_data_d = i_data;
              out_halt_d = i_halt;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              out_data_d = i_data;
              out_halt_d = i_halt;
            end else if (in_fire) begin
              state_d     = ST_FULL;
              skid_data_d = i_data;
              skid_halt_d = i_halt;
            end else if (out_fire) begin
              state_d    = ST_EMPTY;
              out_data_d = '0;
              out_halt_d = 1'b0;
            end
          end
          ST_FULL: begin
            // o_ready is low here, so only the drain side can move.
            if (out_fire) begin
              state_d     = ST_ONE;
              out_data_d  = skid_data_q;
              out_halt_d  = skid_halt_q;
              skid_data_d = '0;
              skid_halt_d = 1'b0;
            end
          end
          default: begin
            state_d     = ST_EMPTY;
            out_data_d  = '0;
            out_halt_d  = 1'b0;
            skid_data_d = '0;
            skid_halt_d = 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_halt_q  <= 1'b0;
      skid_data_q <= '0;
      skid_halt_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_halt_q  <= out_halt_d;
      skid_data_q <= skid_data_d;
      skid_halt_q <= skid_halt_d;
      halted_q    <= halted_d;
    end
  end

`ifdef STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Upstream stall counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Cycles lost to a permanent halt are not back-pressure and are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_step && i_valid && !o_ready && !halted_q) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_latch_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_latch_skid
//
// Drives two instances with identical stimulus: one with a wide stall counter
// and one with CNT_W=2 to expose counter saturation. A queue-based reference
// model tracks the buffered entries, the sticky halt flag and an unbounded
// stall count; the expected counter value is that count clipped to the
// counter width (or 0 when STALL_CNT_EN is not defined).
// -----------------------------------------------------------------------------
module tb_pipe_latch_skid;

  localparam int DW  = 16;
  localparam int CWA = 16;
  localparam int CWB = 2;

  logic          clk;
  logic          rst;
  logic          i_step;
  logic          i_flush;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_halt;
  logic          i_ready;

  logic           a_ready, a_valid, a_halt, a_halted;
  logic [DW-1:0]  a_data;
  logic [CWA-1:0] a_cnt;
  logic           b_ready, b_valid, b_halt, b_halted;
  logic [DW-1:0]  b_data;
  logic [CWB-1:0] b_cnt;

  pipe_latch_skid #(.DATA_W(DW), .CNT_W(CWA)) dut_a (
    .clk(clk), .rst(rst), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(a_ready), .i_data(i_data), .i_halt(i_halt),
    .o_valid(a_valid), .i_ready(i_ready), .o_data(a_data), .o_halt(a_halt),
    .o_halted(a_halted), .o_stall_cnt(a_cnt)
  );

  pipe_latch_skid #(.DATA_W(DW), .CNT_W(CWB)) dut_b (
    .clk(clk), .rst(rst), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(b_ready), .i_data(i_data), .i_halt(i_halt),
    .o_valid(b_valid), .i_ready(i_ready), .o_data(b_data), .o_halt(b_halt),
    .o_halted(b_halted), .o_stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of {halt, data}, capacity 2.
  logic [DW:0] mq[$];
  logic        m_halted;
  longint      m_stall;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int w);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
`ifdef STALL_CNT_EN
    return (m_stall > maxv) ? 64'(maxv) : 64'(m_stall);
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    m_halted = 1'b0;
    m_stall  = 0;
  endtask

  // One clock cycle: apply inputs at negedge, check, advance model, wait edge.
  task automatic cyc(input logic r, input logic st, input logic fl, input logic v,
                     input logic [DW-1:0] d, input logic h, input logic rd);
    logic        e_rdy, e_vld, in_f, out_f;
    logic [DW:0] head;
    rst = r; i_step = st; i_flush = fl; i_valid = v; i_data = d; i_halt = h; i_ready = rd;
    #1;
    e_rdy = st & (mq.size() < 2) & ~m_halted;
    e_vld = (mq.size() > 0);
    head  = e_vld ? mq[0] : '0;
    check_eq("ready_a",  64'(a_ready),  64'(e_rdy));
    check_eq("valid_a",  64'(a_valid),  64'(e_vld));
    check_eq("data_a",   64'(a_data),   64'(head[DW-1:0]));
    check_eq("halt_a",   64'(a_halt),   64'(head[DW]));
    check_eq("halted_a", 64'(a_halted), 64'(m_halted));
    check_eq("cnt_a",    64'(a_cnt),    exp_cnt(CWA));
    check_eq("valid_b",  64'(b_valid),  64'(e_vld));
    check_eq("data_b",   64'(b_data),   64'(head[DW-1:0]));
    check_eq("cnt_b",    64'(b_cnt),    exp_cnt(CWB));
    if (r) begin
      model_clear();
    end else if (st) begin
      in_f  = v & e_rdy;
      out_f = e_vld & rd;
      if (v && !e_rdy && !m_halted) m_stall++;
      if (out_f) begin
        if (mq[0][DW]) m_halted = 1'b1;
        void'(mq.pop_front());
      end
      if (fl) mq.delete();
      else if (in_f) mq.push_back({h, d});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_step = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_data = '0; i_halt = 1'b0; i_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then streaming
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h10, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h11, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h12, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Back-pressure: A, B buffered, 3 stalled cycles, then drain
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hA, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hB, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hC, 1'b0, 1'b0);
`ifdef STALL_CNT_EN
    check_eq("bp_cnt3", 64'(a_cnt), 64'd3);
`else
    check_eq("bp_cnt0", 64'(a_cnt), 64'd0);
`endif
    check_eq("bp_hold", 64'(a_data), 64'hA);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Flush while FULL, with a same-cycle push that must be dropped
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hA, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hB, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hC, 1'b0, 1'b0);
    check_eq("flush_vld", 64'(a_valid), 64'd0);
    check_eq("flush_rdy", 64'(a_ready), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Step gating: frozen while i_step=0, then resume
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h21, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h22, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h33, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h44, 1'b0, 1'b1);

    // Halt: 0x5 with halt, then 0x6; sticky halted until reset
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h5, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h6, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h7, 1'b0, 1'b1);
    check_eq("halt_sticky", 64'(a_halted), 64'd1);
    do_reset();

    // Saturation: 6 stalled cycles on the 2-bit instance
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h2, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) < 7),
          DW'($urandom),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
